// File: rtl/e_muldiv_unit_pkg.sv
// mdu_pkg: start codes, FSM states and default latencies for the E-stage
// multiply/divide unit. Optional madd support is selected by MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_MULT  = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_DIV   = 3'd4,
        MDU_MADD  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_DEFAULT_MUL_CYCLES = 5;
    localparam int unsigned MDU_DEFAULT_DIV_CYCLES = 10;
    localparam int unsigned MDU_CNT_W              = 4;

`ifdef MDU_MADD_EN
    localparam bit MDU_MADD_SUPPORTED = 1'b1;
`else
    localparam bit MDU_MADD_SUPPORTED = 1'b0;
`endif

    // True for start codes that launch an operation; 6/7 (and 5 without madd) are no-ops.
    function automatic logic mdu_start_valid(input logic [2:0] code);
        return (code == MDU_MULTU) || (code == MDU_MULT) ||
               (code == MDU_DIVU)  || (code == MDU_DIV)  ||
               (MDU_MADD_SUPPORTED && (code == MDU_MADD));
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] code);
        return (code == MDU_DIVU) || (code == MDU_DIV);
    endfunction

endpackage

// File: rtl/e_muldiv_unit_compute.sv
// mdu_compute: combinational datapath of the multiply/divide unit.
// Produces the would-be HI/LO for the requested start code; for no-op codes
// it passes the committed HI/LO through. madd exists only with MDU_MADD_EN.
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [2:0]  start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_tmp_o,
    output logic [31:0] lo_tmp_o,
    output logic        div_by_zero_o
);

    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Shared multiplier and magnitude divider; signed division works on
    // magnitudes so 0x80000000 / -1 needs no special overflow path.
    always_comb begin
        is_signed = (start_i == MDU_MULT) || (start_i == MDU_DIV) ||
                    (start_i == MDU_MADD);
        ext_a = {(is_signed ? {32{a_i[31]}} : 32'h0), a_i};
        ext_b = {(is_signed ? {32{b_i[31]}} : 32'h0), b_i};
        prod  = ext_a * ext_b;

        dvd = (is_signed && a_i[31]) ? (32'h0 - a_i) : a_i;
        dvs = (is_signed && b_i[31]) ? (32'h0 - b_i) : b_i;
        quo = (dvs == 32'h0) ? 32'h0 : (dvd / dvs);
        rem = (dvs == 32'h0) ? 32'h0 : (dvd % dvs);
        quo_s = (a_i[31] ^ b_i[31]) ? (32'h0 - quo) : quo;
        rem_s = a_i[31] ? (32'h0 - rem) : rem;
    end

    // Result select by start code.
    always_comb begin
        hi_tmp_o      = hi_i;
        lo_tmp_o      = lo_i;
        div_by_zero_o = 1'b0;
        case (start_i)
            MDU_MULTU, MDU_MULT: begin
                hi_tmp_o = prod[63:32];
                lo_tmp_o = prod[31:0];
            end
            MDU_DIVU: begin
                div_by_zero_o = (b_i == 32'h0);
                hi_tmp_o      = rem;
                lo_tmp_o      = quo;
            end
            MDU_DIV: begin
                div_by_zero_o = (b_i == 32'h0);
                hi_tmp_o      = rem_s;
                lo_tmp_o      = quo_s;
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                {hi_tmp_o, lo_tmp_o} = {hi_i, lo_i} + prod;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: E-stage HI/LO multiply/divide unit with busy for stall
// generation and combinational mfhi/mflo read. Build option: MDU_MADD_EN.
module e_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MDU_DEFAULT_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = MDU_DEFAULT_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDaddress,
    input  logic        MD_write_enable,
    input  logic        req,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            hi_q, hi_d;
    logic [31:0]            lo_q, lo_d;
    logic [31:0]            hi_tmp_q, hi_tmp_d;
    logic [31:0]            lo_tmp_q, lo_tmp_d;
    logic                   dz_q, dz_d;

    logic [31:0]            c_hi;
    logic [31:0]            c_lo;
    logic                   c_dz;

    mdu_compute u_compute (
        .start_i       (start),
        .a_i           (A),
        .b_i           (B),
        .hi_i          (hi_q),
        .lo_i          (lo_q),
        .hi_tmp_o      (c_hi),
        .lo_tmp_o      (c_lo),
        .div_by_zero_o (c_dz)
    );

    // State, counter, pending result and committed HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state: launch/move-to in IDLE, count down and commit in BUSY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (!req && mdu_start_valid(start)) begin
                    state_d  = BUSY;
                    cnt_d    = mdu_is_div(start) ? MDU_CNT_W'(DIV_CYCLES)
                                                 : MDU_CNT_W'(MUL_CYCLES);
                    hi_tmp_d = c_hi;
                    lo_tmp_d = c_lo;
                    dz_d     = c_dz;
                end else if (!req && MD_write_enable) begin
                    if (MDaddress) hi_d = A;
                    else           lo_d = A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= MDU_CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs always reflect committed registers only.
    always_comb begin
        busy    = (state_q == BUSY);
        rd_data = MDaddress ? hi_q : lo_q;
        hi      = hi_q;
        lo      = lo_q;
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed self-checking bench for e_muldiv_unit (MUL_CYCLES=5, DIV_CYCLES=10).
module tb_e_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic [2:0]  start;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDaddress;
    logic        MD_write_enable;
    logic        req;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    e_muldiv_unit #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .A               (A),
        .B               (B),
        .MDaddress       (MDaddress),
        .MD_write_enable (MD_write_enable),
        .req             (req),
        .busy            (busy),
        .rd_data         (rd_data),
        .hi              (hi),
        .lo              (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic addr, input logic [31:0] val);
        MD_write_enable = 1'b1;
        MDaddress       = addr;
        A               = val;
        tick();
        MD_write_enable = 1'b0;
    endtask

    // Issue one operation and count how many sampled cycles busy stays high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start = op;
        A     = a;
        B     = b;
        tick();
        start = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check_eq({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int n;
        reset_n         = 1'b0;
        start           = 3'd0;
        A               = '0;
        B               = '0;
        MDaddress       = 1'b0;
        MD_write_enable = 1'b0;
        req             = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);
        run_op("mult", 3'd2, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", 3'd4, 32'd7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        // Move-to both registers, then divide by zero must leave them intact.
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        MDaddress = 1'b1; #1;
        check_eq("rd_hi", rd_data, 32'h11);
        MDaddress = 1'b0; #1;
        check_eq("rd_lo", rd_data, 32'h22);
        run_op("divu_zero", 3'd3, 32'h1234, 32'h0, 10, 32'h11, 32'h22);

        mt(1'b1, 32'hABCD);
        check_eq("mthi_hi", hi, 32'hABCD);
        check_eq("mthi_lo", lo, 32'h22);
        MDaddress = 1'b1; #1;
        check_eq("mthi_rd", rd_data, 32'hABCD);

        // Write and new start during BUSY are both ignored.
        start = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 1) begin
                MD_write_enable = 1'b1; MDaddress = 1'b0; A = 32'hDEAD;
            end else if (n == 2) begin
                MD_write_enable = 1'b0; start = 3'd4; A = 32'd9; B = 32'd0;
            end else if (n == 3) begin
                start = 3'd0;
            end
            tick();
            if (n == 1) check_eq("busy_write_lo", lo, 32'h22);
        end
        check_eq("busy_ign_cycles", 32'(n), 32'd5);
        check_eq("busy_ign_hi", hi, 32'h0);
        check_eq("busy_ign_lo", lo, 32'hC);
        tick();
        check_eq("busy_ign_norestart", 32'(busy), 32'd0);

        // Start and write in the same cycle: start wins.
        start = 3'd1; A = 32'd2; B = 32'd3; MD_write_enable = 1'b1; MDaddress = 1'b1;
        tick();
        start = 3'd0; MD_write_enable = 1'b0;
        check_eq("startwins_hi", hi, 32'h0);
        check_eq("startwins_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check_eq("startwins_cycles", 32'(n), 32'd5);
        check_eq("startwins_lo", lo, 32'd6);

        // Flush suppresses start and write.
        start = 3'd2; A = 32'd7; B = 32'd7; req = 1'b1;
        tick();
        start = 3'd0;
        check_eq("flush_start_busy", 32'(busy), 32'd0);
        MD_write_enable = 1'b1; MDaddress = 1'b0; A = 32'h5555;
        tick();
        MD_write_enable = 1'b0; req = 1'b0;
        tick();
        check_eq("flush_busy2", 32'(busy), 32'd0);
        check_eq("flush_hi", hi, 32'h0);
        check_eq("flush_lo", lo, 32'd6);

        // Undefined codes are no-ops.
        run_op("code6", 3'd6, 32'd5, 32'd5, 0, 32'h0, 32'd6);
        run_op("code7", 3'd7, 32'd5, 32'd5, 0, 32'h0, 32'd6);

        // madd: accumulates with the feature, no-op without.
        mt(1'b1, 32'h0);
        mt(1'b0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("madd", 3'd5, 32'd1, 32'd1, 5, 32'h1, 32'h0);
`else
        run_op("madd_off", 3'd5, 32'd1, 32'd1, 0, 32'h0, 32'hFFFF_FFFF);
`endif

        // Asynchronous reset in the third busy cycle.
        mt(1'b1, 32'h55);
        start = 3'd4; A = 32'd100; B = 32'd7;
        tick();
        start = 3'd0;
        tick();
        tick();
        check_eq("arst_pre_busy", 32'(busy), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_hi", hi, 32'h0);
        check_eq("arst_lo", lo, 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_eq("arst_after_busy", 32'(busy), 32'd0);
        check_eq("arst_after_hi", hi, 32'h0);
        check_eq("arst_after_lo", lo, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
Multiply/divide unit (HI/LO) in the E stage, directly downstream of the E-stage control decode. It consumes the 3-bit start code, the HI/LO select and the move-to write enable, together with the forwarded rs/rt operands. It runs a multi-cycle operation and exposes busy, which the hazard unit uses for stalls. It returns HI or LO combinationally for mfhi/mflo.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu (and madd when enabled); range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; range 1..15

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  3  operation: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 madd (only with the optional feature)
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
MDaddress  input  1  1 = HI, 0 = LO; selects both the read and the move-to target
MD_write_enable  input  1  mthi/mtlo write strobe
req  input  1  exception/interrupt flush of the E instruction; suppresses start and write this cycle
busy  output  1  operation in progress
rd_data  output  32  MDaddress ? HI : LO, combinational
hi  output  32  HI register, for debug
lo  output  32  LO register, for debug

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0, state IDLE.
  - Any pending result is discarded.
- States: IDLE, BUSY.
- IDLE → BUSY when start∈{1..4} (or 5 with the feature) and req=0.
  - The edge latches the result into internal hi_tmp/lo_tmp, computed from A/B in that cycle.
  - The counter is loaded with MUL_CYCLES or DIV_CYCLES.
  - busy rises in the next cycle.
- BUSY: the counter decrements each cycle. On the edge where the counter reaches 1:
  - HI←hi_tmp, LO←lo_tmp;
  - busy falls;
  - state → IDLE.
  - busy is therefore high for exactly N cycles; the new HI/LO is visible in the cycle busy first reads 0.
- Upstream stall contract: stall mult/div/mfhi/mflo/mthi/mtlo in E while (busy | start≠0). The block does not rely on this contract:
  - start while BUSY: ignored.
  - MD_write_enable while BUSY: ignored.
- Arithmetic:
  - multu: {HI,LO} = unsigned 32×32 → 64.
  - mult: signed 32×32 → 64.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div/divu with B=0):
  - The operation still occupies DIV_CYCLES with busy high.
  - HI/LO stay unchanged at completion.
- Move-to: in IDLE with MD_write_enable=1 and req=0, the register selected by MDaddress ← A on the next edge. The other register is unchanged.
- start≠0 and MD_write_enable in the same cycle: start wins; the write is dropped. This cannot occur legally.
- req=1: start and write are both suppressed. An operation already in BUSY is not cancelled; it was issued by an older instruction.
- rd_data always reflects committed HI/LO, never hi_tmp/lo_tmp.
- Undefined start codes (6, 7; and 5 without the feature): treated as none.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: start=5 (madd) computes {HI,LO} ← {HI,LO} + signed(A)×signed(B) modulo 2^64, using HI/LO as committed at the start edge; latency MUL_CYCLES.
- Undefined: code 5 is ignored; no adder logic is generated.

Decomposition:
- Package mdu_pkg holds:
  - start-code constants: MDU_NONE=0, MDU_MULTU=1, MDU_MULT=2, MDU_DIVU=3, MDU_DIV=4, MDU_MADD=5;
  - state encoding: IDLE, BUSY;
  - default cycle counts.
- Sub-module mdu_compute: purely combinational; maps (start, A, B, HI, LO) to {hi_tmp, lo_tmp, div_by_zero}. The parent keeps the FSM, counter and registers.

Test Plan:
- Unsigned multiply: start=1, A=0xFFFFFFFF, B=2 → busy high for 5 cycles; afterwards HI=0x1, LO=0xFFFFFFFE.
- Signed divide: start=4, A=-7 (0xFFFFFFF9), B=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with 0x80000000 / -1 → LO=0x80000000, HI=0.
- Divide by zero: start=3, B=0, prior HI=0x11, LO=0x22 → busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- Move-to and read:
  - MD_write_enable=1, MDaddress=1, A=0xABCD → HI=0xABCD, LO unchanged; rd_data with MDaddress=1 = 0xABCD.
  - A write asserted during BUSY is ignored.
- Flush: start=2 with req=1 → busy stays 0 and HI/LO unchanged. Separately, assert reset_n=0 at busy cycle 3 → busy=0, HI=LO=0 immediately, without waiting for a clock edge.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, start=5, A=1, B=1 → after 5 cycles HI=1, LO=0. Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.
